div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 28 ++
 rtl/div_unit.sv | 192 +++++++++++++++++++
 tb/tb_div_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg
// Shared constants for the multi-cycle divider and the execute stage that
// drives it: FSM state encodings, start/ready handshake levels and the
// word / double-word width constants used for the hi/lo result bus.
package div_unit_pkg;

    // Divider FSM states. DivShort is only reachable when the design is
    // built with DIV_EARLY_EXIT_EN defined.
    typedef enum logic [2:0] {
        DivFree   = 3'd0,
        DivByZero = 3'd1,
        DivOn     = 3'd2,
        DivEnd    = 3'd3,
        DivShort  = 3'd4
    } div_state_t;

    // Handshake levels seen by the execute stage.
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Datapath width constants shared with the execute stage.
    localparam int          RegWidth     = 32;
    localparam int          DoubleRegBus = 2 * RegWidth;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

endpackage

// File: rtl/div_unit.sv
// div_unit
// Multi-cycle restoring shift-subtract divider for DIV (signed) and DIVU.
// One quotient bit is produced per cycle. Signed divides run on operand
// magnitudes and the signs are fixed up on the final edge.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request; held high until the result has been consumed
//   annul_i       abort an in-flight divide (pipeline flush)
//   result_o      {remainder, quotient}
//   ready_o       result valid
//
// Build option:
//   DIV_EARLY_EXIT_EN  when defined, a nonzero divide whose dividend
//                      magnitude is below the divisor magnitude finishes in
//                      two edges via the DivShort state (quotient 0,
//                      remainder = original dividend).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

    div_state_t          state_reg, state_next;
    logic [CntW-1:0]     cnt_reg, cnt_next;
    // Holds the dividend magnitude at start; quotient bits shift in from
    // the LSB as dividend bits shift out of the MSB.
    logic [WIDTH-1:0]    dividend_reg, dividend_next;
    logic [WIDTH-1:0]    divisor_reg, divisor_next;
    logic [WIDTH-1:0]    rem_reg, rem_next;
    logic                neg_q_reg, neg_q_next;
    logic                neg_r_reg, neg_r_next;
    logic [2*WIDTH-1:0]  result_reg, result_next;
    logic                ready_reg, ready_next;

    logic [WIDTH-1:0]    mag1;
    logic [WIDTH-1:0]    mag2;
    logic [WIDTH:0]      shifted;
    logic [WIDTH:0]      diff;
    logic [WIDTH-1:0]    quo_fixed;
    logic [WIDTH-1:0]    rem_fixed;

    // Operand magnitudes; only negated for a signed divide with MSB set.
    assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // Partial remainder with the next dividend bit appended. It needs
    // WIDTH+1 bits because the remainder can be as large as divisor-1,
    // whose MSB may be set. The top bit of the difference is then a clean
    // borrow: set exactly when the trial subtract would go negative.
    assign shifted = {rem_reg, dividend_reg[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_reg};

    assign quo_fixed = neg_q_reg ? (~dividend_reg + 1'b1) : dividend_reg;
    assign rem_fixed = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= DivFree;
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            result_reg   <= '0;
            ready_reg    <= DivResultNotReady;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            rem_reg      <= rem_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            result_reg   <= result_next;
            ready_reg    <= ready_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        rem_next      = rem_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        result_next   = result_reg;
        ready_next    = ready_reg;

        case (state_reg)
            DivFree: begin
                ready_next  = DivResultNotReady;
                result_next = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = DivByZero;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (mag1 < mag2) begin
                        // Quotient is zero and the remainder is the raw
                        // dividend, so no iteration or sign fix is needed.
                        state_next    = DivShort;
                        rem_next      = opdata1_i;
                        dividend_next = '0;
                    end
`endif
                    else begin
                        state_next    = DivOn;
                        cnt_next      = '0;
                        dividend_next = mag1;
                        divisor_next  = mag2;
                        rem_next      = '0;
                        neg_q_next    = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r_next    = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
            end

            DivByZero: begin
                state_next  = DivEnd;
                result_next = '0;
                ready_next  = DivResultReady;
            end

            DivShort: begin
                state_next  = DivEnd;
                result_next = {rem_reg, dividend_reg};
                ready_next  = DivResultReady;
            end

            DivOn: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    ready_next  = DivResultNotReady;
                    result_next = '0;
                end else if (cnt_reg != LastCnt) begin
                    if (!diff[WIDTH]) begin
                        rem_next      = diff[WIDTH-1:0];
                        dividend_next = {dividend_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_next      = shifted[WIDTH-1:0];
                        dividend_next = {dividend_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    state_next  = DivEnd;
                    result_next = {rem_fixed, quo_fixed};
                    ready_next  = DivResultReady;
                end
            end

            DivEnd: begin
                // Annul is deliberately ignored here: execute drops start_i
                // on a flush, which releases the unit.
                if (start_i == DivStop) begin
                    state_next  = DivFree;
                    ready_next  = DivResultNotReady;
                    result_next = '0;
                end
            end

            default: begin
                state_next  = DivFree;
                ready_next  = DivResultNotReady;
                result_next = '0;
            end
        endcase
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit
// Scoreboard bench for div_unit: the driver pushes the expected
// {remainder, quotient} and latency for each divide; a monitor pops and
// compares on every rising edge of ready_o. Expected values come from
// plain 64-bit integer division with C-style truncation.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    typedef struct {
        logic [63:0] res;
        int          start_edge;
        int          lat;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   edge_cnt = 0;
    int   txn      = 0;
    logic prev_ready = 1'b0;

    // Reference: truncating division on 64-bit integers, result taken
    // modulo 2^32. Divide by zero gives 0 after two edges.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b, output int lat);
        longint la, lb, q, r, ma, mb;
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'b0, a});
            lb = longint'({32'b0, b});
        end
        ma = (la < 0) ? -la : la;
        mb = (lb < 0) ? -lb : lb;
        if (b == 32'd0) begin
            lat = 2;
            return 64'd0;
        end
`ifdef DIV_EARLY_EXIT_EN
        lat = (ma < mb) ? 2 : 34;
`else
        lat = (ma < mb) ? 34 : 34;
`endif
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: counts edges and checks each rising ready against the queue.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (ready_o && !prev_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ready: result=%h ready=1, required no ready", result_o);
                end else begin
                    e   = sb.pop_front();
                    lat = edge_cnt - e.start_edge + 1;
                    if (result_o !== e.res || lat != e.lat) begin
                        fails++;
                        $display("FAIL txn%0d_result: result=%h latency=%0d, required result=%h latency=%0d",
                                 e.id, result_o, lat, e.res, e.lat);
                    end else begin
                        $display("[TB] txn %0d ok result=%h latency=%0d", e.id, result_o, lat);
                    end
                end
            end
            prev_ready = ready_o;
        end
    end

    // Drives a start at the current negedge and queues the expectation.
    task automatic issue_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [63:0] r);
        int   lat;
        exp_t e;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        r            = model(sgn, a, b, lat);
        e.res        = r;
        e.start_edge = edge_cnt + 1;
        e.lat        = lat;
        e.id         = txn;
        sb.push_back(e);
        txn++;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: ready=0 after %0d cycles, required ready=1", name, n);
        end
    endtask

    // Waits for the result, holds start, checks stability, releases.
    task automatic finish_div(input logic [63:0] r, input int hold, input string name);
        @(negedge clk);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        wait_ready(name);
        repeat (hold) @(negedge clk);
        tests++;
        if (ready_o !== 1'b1 || result_o !== r) begin
            fails++;
            $display("FAIL %s_hold: ready=%b result=%h, required ready=1 result=%h",
                     name, ready_o, result_o, r);
        end
        start_i = 1'b0;
        @(negedge clk);
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL %s_release: ready=%b result=%h, required ready=0 result=0",
                     name, ready_o, result_o);
        end
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input string name);
        logic [63:0] r;
        @(negedge clk);
        issue_div(sgn, a, b, r);
        finish_div(r, hold, name);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL %s: ready=%b result=%h, required ready=0 result=0",
                     name, ready_o, result_o);
        end
    endtask

    initial begin
        logic [63:0] r;
        logic        sgn;
        logic [31:0] a, b;
        int          s;

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        // Directed cases
        run_div(1'b0, 32'd100, 32'd7, 3, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_m7_2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_overflow");
        run_div(1'b0, 32'd5, 32'd0, 2, "divu_by_zero");
        run_div(1'b0, 32'd5, 32'd7, 0, "divu_5_7");

        // Annul after ten iterations, then an immediate new divide
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        s            = edge_cnt + 1;
        while (edge_cnt < s + 10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check_zero("annul_free");
        issue_div(1'b0, 32'd9, 32'd3, r);
        finish_div(r, 1, "after_annul");

        // Reset mid-divide with start still high
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_in_on");
        rst     = 1'b0;
        start_i = 1'b0;
        repeat (40) @(negedge clk);

        // Reset while the result is being held
        @(negedge clk);
        issue_div(1'b0, 32'd100, 32'd7, r);
        @(negedge clk);
        wait_ready("rst_in_end");
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_in_end");
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        // Randomized divides
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
                2: b = 32'd0;
                3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1; end
                4: b = $urandom_range(1, 9);
                default: begin a = -($urandom_range(1, 1000)); b = -($urandom_range(1, 50)); end
            endcase
            run_div(sgn, a, b, $urandom_range(0, 3), "random");
        end

        repeat (5) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
